// File: rtl/ultrasonido_echo_timer.sv
// Ultrasonic echo timer: trigger pulse, then echo width in TICK_CYCLES units; ULTRASONIDO_ECHO_SYNC_EN adds a 2-flop echo synchronizer.
// Registered outputs; echo edge latency 1 cycle (3 with sync); start is ignored while busy, no queuing or backpressure.
module ultrasonido_echo_timer #(
   parameter int TRIG_CYCLES = 500,
   parameter int TICK_CYCLES = 1450,
   parameter int WAIT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       echo,
   output logic       trigger,
   output logic [7:0] count,
   output logic       calculate,
   output logic       busy,
   output logic       timeout
);
   localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_ECHO,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [TICK_W-1:0] presc_q, presc_d;
   logic [7:0]        count_q, count_d;
   logic              timeout_q, timeout_d;
   logic              trigger_q, trigger_d;
   logic              calculate_q, calculate_d;
   logic              busy_q, busy_d;
   logic              echo_s, echo_prev_q, echo_prev_d;
   logic              echo_rise, echo_fall;

`ifdef ULTRASONIDO_ECHO_SYNC_EN
   logic sync1_q, sync1_d, sync2_q, sync2_d;

   assign sync1_d = echo;
   assign sync2_d = sync1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign echo_s = sync2_q;
`else
   assign echo_s = echo;
`endif

   // Previous level tracks continuously, so echo already high on WAIT_ECHO entry never looks like a rise
   assign echo_prev_d = echo_s;
   assign echo_rise   = echo_s & ~echo_prev_q;
   assign echo_fall   = ~echo_s & echo_prev_q;

   always_comb begin
      state_d    = state_q;
      trig_cnt_d = '0;
      wait_cnt_d = '0;
      presc_d    = '0;
      count_d    = count_q;
      timeout_d  = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d   = '0;
               timeout_d = 1'b0;
               state_d   = S_TRIG;
            end
         end
         S_TRIG: begin
            if (trig_cnt_q == TRIG_LAST) begin
               state_d = S_WAIT_ECHO;
            end else begin
               trig_cnt_d = trig_cnt_q + 1'b1;
            end
         end
         S_WAIT_ECHO: begin
            if (echo_rise) begin
               state_d = S_MEASURE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               count_d   = '0;
               state_d   = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_MEASURE: begin
            // Every MEASURE cycle, including the one closed by the fall, is one echo-high cycle
            if (presc_q == TICK_LAST) begin
               count_d = count_q + 8'd1;
               if (count_q == 8'd254) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
            if (echo_fall) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      trigger_d   = (state_d == S_TRIG);
      calculate_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         trig_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         presc_q     <= '0;
         count_q     <= '0;
         timeout_q   <= 1'b0;
         trigger_q   <= 1'b0;
         calculate_q <= 1'b0;
         busy_q      <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         trig_cnt_q  <= trig_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         presc_q     <= presc_d;
         count_q     <= count_d;
         timeout_q   <= timeout_d;
         trigger_q   <= trigger_d;
         calculate_q <= calculate_d;
         busy_q      <= busy_d;
         echo_prev_q <= echo_prev_d;
      end
   end

   assign trigger   = trigger_q;
   assign count     = count_q;
   assign calculate = calculate_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_ultrasonido_echo_timer.sv
// Directed bench for ultrasonido_echo_timer with TRIG=4, TICK=3, WAIT=20 (default build, no echo synchronizer).
module tb_ultrasonido_echo_timer;
   logic       clk;
   logic       reset;
   logic       start;
   logic       echo;
   logic       trigger;
   logic [7:0] count;
   logic       calculate;
   logic       busy;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   ultrasonido_echo_timer #(
      .TRIG_CYCLES(4),
      .TICK_CYCLES(3),
      .WAIT_CYCLES(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .echo(echo),
      .trigger(trigger),
      .count(count),
      .calculate(calculate),
      .busy(busy),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Times are in cycles after the edge where trigger falls; rise = -1 means no echo
   typedef struct {
      string name;
      bit    pre_high;
      int    pre_fall;
      int    rise;
      int    high;
      bit    stray;
      int    exp_cnt;
      bit    exp_to;
      int    exp_calc;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_start(input bit stray, output int n);
      n = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (trigger === 1'b1 && n < 50) begin
         n++;
         start = (stray && n == 2);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int         trig_len;
      int         calc_n;
      int         calc_t;
      int         busy_after;
      int         limit;
      int         t;
      logic [7:0] cnt_at_calc;
      logic       to_at_calc;
      echo = v.pre_high;
      do_start(v.stray, trig_len);
      check({v.name, ".trig_len"}, trig_len, 4);
      calc_n      = 0;
      calc_t      = -1;
      busy_after  = -1;
      cnt_at_calc = 8'hxx;
      to_at_calc  = 1'bx;
      limit = ((v.rise + v.high > v.exp_calc) ? v.rise + v.high : v.exp_calc) + 4;
      t = 0;
      while (t < limit) begin
         if (t == v.pre_fall) echo = 1'b0;
         if (v.rise >= 0 && t == v.rise) echo = 1'b1;
         if (v.rise >= 0 && t == v.rise + v.high) echo = 1'b0;
         start = (v.stray && t == v.rise + 10);
         @(posedge clk); #1;
         t++;
         if (calculate === 1'b1) begin
            calc_n++;
            calc_t      = t;
            cnt_at_calc = count;
            to_at_calc  = timeout;
         end
         if (calc_t >= 0 && t == calc_t + 1) busy_after = int'(busy);
      end
      start = 1'b0;
      echo  = 1'b0;
      check({v.name, ".calc_strobes"}, calc_n, 1);
      check({v.name, ".calc_time"}, calc_t, v.exp_calc);
      check({v.name, ".count"}, cnt_at_calc, v.exp_cnt);
      check({v.name, ".timeout"}, to_at_calc, v.exp_to);
      check({v.name, ".busy_after"}, busy_after, 0);
      check({v.name, ".count_held"}, count, v.exp_cnt);
      check({v.name, ".timeout_held"}, timeout, v.exp_to);
   endtask

   initial begin
      int trig_len;
      int calc_n;
      reset = 1'b1;
      start = 1'b0;
      echo  = 1'b0;
      #12;
      check("rst.trigger", trigger, 0);
      check("rst.count", count, 0);
      check("rst.calculate", calculate, 0);
      check("rst.busy", busy, 0);
      check("rst.timeout", timeout, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      //          name            pre   pfall rise high stray cnt  to    calc
      vecs[0]  = '{"nominal",     1'b0, -1,   5,   30,  1'b0, 10,  1'b0, 36};
      vecs[1]  = '{"partial",     1'b0, -1,   5,   32,  1'b0, 10,  1'b0, 38};
      vecs[2]  = '{"no_echo",     1'b0, -1,   -1,  0,   1'b0, 0,   1'b1, 20};
      vecs[3]  = '{"saturate",    1'b0, -1,   5,   900, 1'b0, 255, 1'b1, 771};
      vecs[4]  = '{"stray_start", 1'b0, -1,   5,   30,  1'b1, 10,  1'b0, 36};
      vecs[5]  = '{"sub_tick",    1'b0, -1,   5,   2,   1'b0, 0,   1'b0, 8};
      vecs[6]  = '{"one_tick",    1'b0, -1,   5,   3,   1'b0, 1,   1'b0, 9};
      vecs[7]  = '{"late_ok",     1'b0, -1,   19,  6,   1'b0, 2,   1'b0, 26};
      vecs[8]  = '{"too_late",    1'b0, -1,   20,  6,   1'b0, 0,   1'b1, 20};
      vecs[9]  = '{"pre_high",    1'b1, 3,    8,   9,   1'b0, 3,   1'b0, 18};
      vecs[10] = '{"max_no_sat",  1'b0, -1,   5,   764, 1'b0, 254, 1'b0, 770};

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i]);
         @(posedge clk); #1;
      end

      // Reset in the middle of MEASURE: outputs clear without waiting for a clock edge
      do_start(1'b0, trig_len);
      check("mid_rst.trig_len", trig_len, 4);
      for (int t = 0; t < 13; t++) begin
         if (t == 2) echo = 1'b1;
         @(posedge clk); #1;
      end
      check("mid_rst.count_before", count, 3);
      check("mid_rst.busy_before", busy, 1);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst.trigger", trigger, 0);
      check("mid_rst.count", count, 0);
      check("mid_rst.calculate", calculate, 0);
      check("mid_rst.busy", busy, 0);
      check("mid_rst.timeout", timeout, 0);
      #2;
      reset = 1'b0;
      echo  = 1'b0;
      calc_n = 0;
      for (int t = 0; t < 30; t++) begin
         @(posedge clk); #1;
         if (calculate === 1'b1) calc_n++;
      end
      check("mid_rst.no_calc", calc_n, 0);
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ultrasonido_echo_timer.md
# ultrasonido_echo_timer

Front-end timing stage of the ultrasonic ranging path. On a start request it drives the sensor trigger pulse, then times the returned echo pulse in fixed prescaled ticks. It delivers a stable 8-bit `count` plus a one-cycle `calculate` strobe, which directly feed the halving divisor stage downstream.

## Interface
- `TRIG_CYCLES`, 500: trigger high time in clk cycles (10 µs at 50 MHz).
- `TICK_CYCLES`, 1450: clk cycles per count unit (29 µs at 50 MHz).
  - Count/2 downstream ≈ distance in cm.
- `WAIT_CYCLES`, 1500000: maximum clk cycles from trigger end to echo rising edge (30 ms).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: measurement request, sampled in IDLE only.
- `echo` in 1: sensor echo line, asynchronous to clk.
- `trigger` out 1: sensor trigger pulse.
- `count` out 8: echo width in ticks; stable from DONE until next accepted start.
- `calculate` out 1: one-cycle strobe, `count` valid.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: last measurement had no echo or saturated; same lifetime as `count`.

## Operation
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
- IDLE, `start`=1: clear `count` and `timeout`, go to TRIG.
  - `start` in any other state is ignored; no queuing.
- TRIG: `trigger`=1 for exactly `TRIG_CYCLES` cycles, then WAIT_ECHO.
- WAIT_ECHO:
  - Echo rising edge (sync'd `echo` 0→1): go to MEASURE.
  - Otherwise, after `WAIT_CYCLES` cycles: `timeout`=1, `count`=0, go to DONE.
  - Echo already high on WAIT_ECHO entry is not an edge; wait for a fall then a rise.
- MEASURE:
  - Prescaler counts 0..`TICK_CYCLES`-1; on wrap, `count`+1.
  - Result: `count` = floor(echo_high_cycles / `TICK_CYCLES`).
  - Echo falling edge: go to DONE; partial tick discarded.
  - `count` reaching 255: `timeout`=1, go to DONE immediately. No wrap-around to 0.
- DONE: `calculate`=1 for exactly one cycle, then IDLE. `count` and `timeout` held.
- Counter widths sized with $clog2 of the respective parameter; prescaler and wait counter clear on every state entry.
- Reset, including mid-operation: state IDLE, `trigger`=0, `count`=0, `calculate`=0, `busy`=0, `timeout`=0, all counters 0, sync flops 0. No `calculate` is issued for an aborted measurement.

## Timing
- `start` high at edge N: `busy`=1 and `trigger`=1 from N+1 through N+`TRIG_CYCLES`; `trigger` low at N+`TRIG_CYCLES`+1.
- Echo-edge latency: 2 cycles (synchronizer) + 1 cycle (edge detect) with `ECHO_SYNC_EN`; 1 cycle without.
  - The same latency applies to both edges, so measured width is unaffected.
- Echo fall detected at edge M: `calculate`=1 during cycle M+1, `busy`=0 at M+2.
- Earliest re-start: `start` high in the cycle after `calculate`.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ULTRASONIDO_ECHO_SYNC_EN` defined:
  - `echo` passes through a two-flop synchronizer before edge detection.
  - Required when `echo` comes from the sensor pin.
- Not defined:
  - `echo` is registered once for edge detection only.
  - For benches or a source already synchronous to `clk`.
  - Edge latency drops by 2 cycles; counts unchanged.

## Test plan
Parameters: `TRIG_CYCLES`=4, `TICK_CYCLES`=3, `WAIT_CYCLES`=20.
- Nominal: `start` pulse, echo rises 5 cycles after trigger falls, stays high 30 cycles → `trigger` high exactly 4 cycles; single `calculate` with `count`=10, `timeout`=0.
- Partial tick: echo high 32 cycles → `count`=10.
- No echo: `start`, echo held 0 → `calculate` 20 cycles after trigger falls; `count`=0, `timeout`=1; `busy` low next cycle.
- Saturation: echo high 900 cycles → `calculate` after 765 MEASURE cycles; `count`=255, `timeout`=1; later echo fall ignored.
- `start` pulsed in TRIG and MEASURE → ignored; exactly one `calculate`; result equals undisturbed run.
- `reset` pulsed mid-MEASURE → all outputs 0 asynchronously, no `calculate`. Next `start` gives a correct fresh result.
